fsm_if_frame: RTL
=================

Name: fsm_if_frame

Overview:
- Parametrised successor to the fixed 40-cycle test-interface FSM.
- Owns its frame counter: modulo-PERIOD, no longer an external count40.
- Generates tclk, trst, dq_en and sr_en with run-time programmable enable windows.
- Adds a start/stop handshake, a frame-done pulse and a frame counter. Sits between the test controller and the DUT test port.

Parameters:
- PERIOD, 40, frame length in clk cycles; must be ≥ 4.
- CW, 6, counter width; must satisfy 2^CW ≥ PERIOD.
- TRST_LEN, 2, cycles trst is held high before each run.
- TCLK_HALF, 2, tclk half-period in clk cycles; must be ≥ 1.
- FW, 8, frame counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a run; honoured only in IDLE
- stop  in  1  single-cycle request to end the run at the next frame boundary
- dq_start  in  CW  first count of the dq_en window
- dq_stop  in  CW  count after the last dq_en cycle (exclusive)
- sr_start  in  CW  first count of the sr_en window
- sr_stop  in  CW  count after the last sr_en cycle (exclusive)
- count  out  CW  current frame position
- tclk  out  1  divided test clock
- trst  out  1  test reset
- dq_en  out  1  data-quantiser enable
- sr_en  out  1  shift-register enable
- frame_done  out  1  one-cycle pulse on the last cycle of each frame
- frame_cnt  out  FW  completed frames since start; wraps
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; stop_pend=0; latched windows=0.
- All outputs are registered.
- The window, tclk and frame_done outputs are aligned to the count value presented in the same cycle.
- States:
  - IDLE: count=0, tclk=0, trst=0, enables=0.
    - start=1 → TRST next cycle.
    - Clear frame_cnt and stop_pend on start.
  - TRST: trst=1 for exactly TRST_LEN cycles, count=0.
    - Latch the four window inputs on the last TRST cycle.
    - Then RUN, with count=0 on the first RUN cycle.
  - RUN: count increments by 1 each cycle and wraps PERIOD-1 → 0.
    - On count=PERIOD-1: frame_done=1.
    - frame_cnt+1 is visible on the following cycle.
    - Re-latch the window inputs for the next frame.
    - If stop_pend is set, go to IDLE instead of wrapping.
- Windows:
  - dq_en=1 iff RUN and dq_start ≤ count < dq_stop, using latched values.
  - If start ≥ stop, the window is empty and the enable stays 0.
  - sr_en follows the same rule with its own latched values.
- tclk:
  - 0 outside RUN.
  - In RUN, tclk=0 at count=0, then toggles every TCLK_HALF cycles.
  - The phase restarts at each frame start, even if PERIOD is not a multiple of 2·TCLK_HALF.
- stop:
  - Any cycle of TRST or RUN sets stop_pend.
  - stop in TRST still completes TRST and one full frame.
  - Ignored in IDLE.
  - start+stop in the same IDLE cycle: start is taken, stop is discarded.
- start outside IDLE is ignored.
- Reset mid-run: immediate IDLE with all outputs 0. Latched windows and counters are cleared.
- Window inputs changing mid-frame have no effect until the next latch point.

Optional Feature:
- FSM_IF_SINGLE_FRAME_EN defined:
  - Adds input port single (1 bit).
  - If single=1 in the start cycle, the run stops after exactly one frame: frame_done, then IDLE, as if stop_pend were set.
  - If single=0, the block behaves as in the base design.
- FSM_IF_SINGLE_FRAME_EN undefined:
  - No single port.
  - A run ends only via stop.

Test Plan:
- Reset: rst_n low at count mid-run → all outputs 0 and state IDLE immediately, asynchronously; after release, busy=0.
- Start sequence (defaults, TRST_LEN=2): start pulse → 2 cycles trst=1, then count=0,1,…,39,0.
  - frame_done high at count=39.
  - frame_cnt=1 on the next cycle.
- Windows: dq 5..10, sr 20..39 → dq_en high exactly at counts 5–9, sr_en high at 20–38.
  - dq_start=10, dq_stop=10 → dq_en never high.
- Window update: change dq window at count=15 → old window persists in the current frame; new window applies from the next count=0.
- tclk (TCLK_HALF=2): count 0–1 tclk=0, 2–3 tclk=1, 4–5 tclk=0, …; phase realigned to 0 at each frame start.
- Stop and ignore cases:
  - stop at count=3 → frame completes to 39 with frame_done, then IDLE with busy=0.
  - start during RUN → no effect.
  - start+stop in the same IDLE cycle → run begins and continues past the first frame.

Source files
------------

// File: rtl/fsm_if_frame.sv
// Test-interface frame sequencer: owns a modulo-PERIOD frame counter and drives tclk, trst, dq_en and sr_en.
// Optional build macro FSM_IF_SINGLE_FRAME_EN adds i_single, which limits a run to exactly one frame.
module fsm_if_frame #(
    parameter int PERIOD    = 40,
    parameter int CW        = 6,
    parameter int TRST_LEN  = 2,
    parameter int TCLK_HALF = 2,
    parameter int FW        = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
`ifdef FSM_IF_SINGLE_FRAME_EN
    input  logic          i_single,
`endif
    input  logic          i_start,
    input  logic          i_stop,
    input  logic [CW-1:0] i_dq_start,
    input  logic [CW-1:0] i_dq_stop,
    input  logic [CW-1:0] i_sr_start,
    input  logic [CW-1:0] i_sr_stop,
    output logic [CW-1:0] o_count,
    output logic          o_tclk,
    output logic          o_trst,
    output logic          o_dq_en,
    output logic          o_sr_en,
    output logic          o_frame_done,
    output logic [FW-1:0] o_frame_cnt,
    output logic          o_busy
);

    localparam int TW = $clog2(TRST_LEN) + 1;
    localparam int HW = $clog2(TCLK_HALF) + 1;
    localparam logic [CW-1:0] LAST      = CW'(PERIOD - 1);
    localparam logic [TW-1:0] TRST_LAST = TW'(TRST_LEN - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(TCLK_HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_TRST, S_RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_trst_cnt;
    logic [HW-1:0] r_hcnt;
    logic          r_tclk;
    logic          r_trst;
    logic          r_dq_en;
    logic          r_sr_en;
    logic          r_frame_done;
    logic [FW-1:0] r_frame_cnt;
    logic          r_busy;
    logic          r_stop_pend;
    logic          r_single;
    logic [CW-1:0] r_dq_start;
    logic [CW-1:0] r_dq_stop;
    logic [CW-1:0] r_sr_start;
    logic [CW-1:0] r_sr_stop;

    state_t        w_state_next;
    logic [CW-1:0] w_count_next;
    logic [TW-1:0] w_trst_cnt_next;
    logic [HW-1:0] w_hcnt_next;
    logic          w_tclk_next;
    logic          w_dq_en_next;
    logic          w_sr_en_next;
    logic          w_frame_done_next;
    logic [FW-1:0] w_frame_cnt_next;
    logic          w_stop_pend_next;
    logic          w_single_next;
    logic          w_single_in;
    logic          w_latch;
    logic          w_run_next;
    logic [CW-1:0] w_dq_lo;
    logic [CW-1:0] w_dq_hi;
    logic [CW-1:0] w_sr_lo;
    logic [CW-1:0] w_sr_hi;

`ifdef FSM_IF_SINGLE_FRAME_EN
    assign w_single_in = i_single;
`else
    assign w_single_in = 1'b0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = '0;
        w_trst_cnt_next  = r_trst_cnt;
        w_stop_pend_next = r_stop_pend;
        w_frame_cnt_next = r_frame_cnt;
        w_single_next    = r_single;
        w_latch          = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A stop arriving with start is deliberately dropped here.
                if (i_start) begin
                    w_state_next     = S_TRST;
                    w_trst_cnt_next  = '0;
                    w_stop_pend_next = 1'b0;
                    w_frame_cnt_next = '0;
                    w_single_next    = w_single_in;
                end
            end
            S_TRST: begin
                if (i_stop) w_stop_pend_next = 1'b1;
                if (r_trst_cnt == TRST_LAST) begin
                    w_state_next = S_RUN;
                    w_latch      = 1'b1;
                end else begin
                    w_trst_cnt_next = r_trst_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (i_stop) w_stop_pend_next = 1'b1;
                if (r_count == LAST) begin
                    w_frame_cnt_next = r_frame_cnt + 1'b1;
                    if (r_stop_pend || i_stop || r_single) begin
                        w_state_next     = S_IDLE;
                        w_stop_pend_next = 1'b0;
                    end else begin
                        w_latch = 1'b1;
                    end
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        w_run_next = (w_state_next == S_RUN);

        // At a latch point the new frame's first cycle must already see the fresh window inputs.
        w_dq_lo = w_latch ? i_dq_start : r_dq_start;
        w_dq_hi = w_latch ? i_dq_stop  : r_dq_stop;
        w_sr_lo = w_latch ? i_sr_start : r_sr_start;
        w_sr_hi = w_latch ? i_sr_stop  : r_sr_stop;

        w_dq_en_next      = w_run_next && (w_count_next >= w_dq_lo) && (w_count_next < w_dq_hi);
        w_sr_en_next      = w_run_next && (w_count_next >= w_sr_lo) && (w_count_next < w_sr_hi);
        w_frame_done_next = w_run_next && (w_count_next == LAST);

        w_tclk_next = r_tclk;
        w_hcnt_next = r_hcnt + 1'b1;
        if (!w_run_next || w_count_next == '0) begin
            w_tclk_next = 1'b0;
            w_hcnt_next = '0;
        end else if (r_hcnt == HALF_LAST) begin
            w_tclk_next = ~r_tclk;
            w_hcnt_next = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_trst_cnt   <= '0;
            r_hcnt       <= '0;
            r_tclk       <= 1'b0;
            r_trst       <= 1'b0;
            r_dq_en      <= 1'b0;
            r_sr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_busy       <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_single     <= 1'b0;
            r_dq_start   <= '0;
            r_dq_stop    <= '0;
            r_sr_start   <= '0;
            r_sr_stop    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_trst_cnt   <= w_trst_cnt_next;
            r_hcnt       <= w_hcnt_next;
            r_tclk       <= w_tclk_next;
            r_trst       <= (w_state_next == S_TRST);
            r_dq_en      <= w_dq_en_next;
            r_sr_en      <= w_sr_en_next;
            r_frame_done <= w_frame_done_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_busy       <= (w_state_next != S_IDLE);
            r_stop_pend  <= w_stop_pend_next;
            r_single     <= w_single_next;
            r_dq_start   <= w_dq_lo;
            r_dq_stop    <= w_dq_hi;
            r_sr_start   <= w_sr_lo;
            r_sr_stop    <= w_sr_hi;
        end
    end

    assign o_count      = r_count;
    assign o_tclk       = r_tclk;
    assign o_trst       = r_trst;
    assign o_dq_en      = r_dq_en;
    assign o_sr_en      = r_sr_en;
    assign o_frame_done = r_frame_done;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_busy       = r_busy;

endmodule
